// File: rtl/rx_link_pkg.sv
// Shared state encoding and statistics widths for the receive link controller.
package rx_link_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        HUNT    = 3'd2,
        LOCKED  = 3'd3,
        RETRAIN = 3'd4
    } link_state_t;

    localparam int STATE_W       = 3;
    localparam int FRAME_CNT_W   = 32;
    localparam int ERR_CNT_W     = 32;
    localparam int RETRAIN_CNT_W = 16;

endpackage

// File: rtl/rx_link_if.sv
// Decoded byte stream from the Manchester decoder into the link controller.
interface rx_link_if;

    logic       byte_valid;
    logic [7:0] decoded_byte;
    logic       tx_end;

    modport master (output byte_valid, decoded_byte, tx_end);
    modport slave  (input  byte_valid, decoded_byte, tx_end);

endinterface

// File: rtl/rx_frame_checker.sv
// Assembles decoded bytes into a frame register and grades each frame on tx_end.
// cmp_* is the same-cycle verdict; done/good are its registered copies.
module rx_frame_checker #(
    parameter int                     FRAME_LEN = 6,
    parameter logic [FRAME_LEN*8-1:0] EXPECTED  = 48'hAABBCCDDEEFF
) (
    input  logic      aclk,
    input  logic      aresetn,
    rx_link_if.slave  rx,
    input  logic      flush,
    output logic      cmp_done,
    output logic      cmp_good,
    output logic      done,
    output logic      good
);

    localparam int            W        = FRAME_LEN * 8;
    localparam int            CW       = $clog2(FRAME_LEN + 2);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_LEN + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);

    logic [W-1:0]  shift_q;
    logic [W-1:0]  shift_next;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          accept;

    // Count saturates one past a full frame so long frames stay distinguishable.
    always_comb begin
        accept     = rx.byte_valid && !flush;
        shift_next = (shift_q << 8) | W'(rx.decoded_byte);
        count_next = (count_q == CNT_SAT) ? count_q : count_q + 1'b1;
        cmp_done   = accept && rx.tx_end;
        cmp_good   = cmp_done && (count_next == CNT_FULL) && (shift_next == EXPECTED);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shift_q <= '0;
            count_q <= '0;
            done    <= 1'b0;
            good    <= 1'b0;
        end else begin
            done <= cmp_done;
            good <= cmp_good;
            if (flush) begin
                shift_q <= '0;
                count_q <= '0;
            end else if (accept) begin
                shift_q <= shift_next;
                count_q <= rx.tx_end ? '0 : count_next;
            end
        end
    end

endmodule

// File: rtl/rx_link_controller.sv
// Receive link supervisor: DRU reset/settle sequencing, frame-based lock detection,
// retrain on repeated errors or silence, and debug statistics.
module rx_link_controller
    import rx_link_pkg::*;
#(
    parameter int                       FRAME_LEN      = 6,
    parameter logic [FRAME_LEN*8-1:0]   EXPECTED       = 48'hAABBCCDDEEFF,
    parameter int                       RST_CYCLES     = 8,
    parameter int                       SETTLE_CYCLES  = 256,
    parameter int                       LOCK_FRAMES    = 4,
    parameter int                       MAX_ERRS       = 3,
    parameter int                       IDLE_TIMEOUT   = 65536,
    parameter logic [FRAME_CNT_W-1:0]   FRAME_CNT_INIT = '0
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     pll_locked,
    rx_link_if.slave                 rx,
    input  logic                     clear_stats,
    output logic                     dru_aresetn,
    output logic                     link_up,
    output logic                     frame_ok,
    output logic                     frame_err,
    output logic [STATE_W-1:0]       state,
    output logic [FRAME_CNT_W-1:0]   frame_cnt,
    output logic [ERR_CNT_W-1:0]     err_cnt,
    output logic [RETRAIN_CNT_W-1:0] retrain_cnt
);

    localparam int            TW          = $clog2(SETTLE_CYCLES);
    localparam int            IW          = $clog2(IDLE_TIMEOUT);
    localparam int            GW          = $clog2(LOCK_FRAMES + 1);
    localparam int            BW          = $clog2(MAX_ERRS + 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] RST_LAST    = TW'(RST_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LAST   = IW'(IDLE_TIMEOUT - 1);
    localparam logic [GW-1:0] LOCK_LAST   = GW'(LOCK_FRAMES - 1);
    localparam logic [BW-1:0] ERR_LAST    = BW'(MAX_ERRS - 1);

    link_state_t   state_q;
    logic [TW-1:0] settle_q;
    logic [IW-1:0] idle_q;
    logic [GW-1:0] good_run_q;
    logic [BW-1:0] bad_run_q;
    logic          in_frames;
    logic          flush;
    logic          timeout;
    logic          retrain_go;
    logic          cmp_done;
    logic          cmp_good;
    logic          chk_done;
    logic          chk_good;

    // A byte arriving on the timeout cycle keeps the link alive.
    assign in_frames  = (state_q == HUNT) || (state_q == LOCKED);
    assign flush      = !pll_locked || !in_frames;
    assign timeout    = in_frames && (idle_q == IDLE_LAST) && !rx.byte_valid;
    assign retrain_go = pll_locked &&
                        ((state_q == LOCKED && cmp_done && !cmp_good && bad_run_q == ERR_LAST) ||
                         timeout);

    assign state     = state_q;
    assign frame_ok  = chk_done && chk_good;
    assign frame_err = chk_done && !chk_good;

    rx_frame_checker #(
        .FRAME_LEN (FRAME_LEN),
        .EXPECTED  (EXPECTED)
    ) u_checker (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .rx       (rx),
        .flush    (flush),
        .cmp_done (cmp_done),
        .cmp_good (cmp_good),
        .done     (chk_done),
        .good     (chk_good)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            dru_aresetn <= 1'b0;
            link_up     <= 1'b0;
            settle_q    <= '0;
            idle_q      <= '0;
            good_run_q  <= '0;
            bad_run_q   <= '0;
        end else if (!pll_locked) begin
            state_q     <= IDLE;
            dru_aresetn <= 1'b0;
            link_up     <= 1'b0;
            settle_q    <= '0;
            idle_q      <= '0;
            good_run_q  <= '0;
            bad_run_q   <= '0;
        end else begin
            idle_q <= (in_frames && !rx.byte_valid) ? idle_q + 1'b1 : '0;
            case (state_q)
                IDLE: begin
                    state_q     <= SETTLE;
                    settle_q    <= '0;
                    dru_aresetn <= 1'b0;
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q     <= HUNT;
                        idle_q      <= '0;
                        dru_aresetn <= 1'b1;
                    end else begin
                        settle_q    <= settle_q + 1'b1;
                        dru_aresetn <= (settle_q >= RST_LAST);
                    end
                end
                HUNT: begin
                    if (cmp_done) begin
                        if (!cmp_good) begin
                            good_run_q <= '0;
                        end else if (good_run_q == LOCK_LAST) begin
                            state_q    <= LOCKED;
                            link_up    <= 1'b1;
                            good_run_q <= '0;
                            bad_run_q  <= '0;
                        end else begin
                            good_run_q <= good_run_q + 1'b1;
                        end
                    end else if (timeout) begin
                        state_q    <= RETRAIN;
                        link_up    <= 1'b0;
                        idle_q     <= '0;
                        good_run_q <= '0;
                        bad_run_q  <= '0;
                    end
                end
                LOCKED: begin
                    if ((cmp_done && !cmp_good && bad_run_q == ERR_LAST) || timeout) begin
                        state_q    <= RETRAIN;
                        link_up    <= 1'b0;
                        idle_q     <= '0;
                        good_run_q <= '0;
                        bad_run_q  <= '0;
                    end else if (cmp_done) begin
                        bad_run_q <= cmp_good ? '0 : bad_run_q + 1'b1;
                    end
                end
                RETRAIN: begin
                    state_q     <= SETTLE;
                    settle_q    <= '0;
                    dru_aresetn <= 1'b0;
                    good_run_q  <= '0;
                    bad_run_q   <= '0;
                end
                default: begin
                    state_q     <= IDLE;
                    dru_aresetn <= 1'b0;
                    link_up     <= 1'b0;
                end
            endcase
        end
    end

    // Frame and error counters wrap together so err_cnt never exceeds frame_cnt.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            frame_cnt   <= FRAME_CNT_INIT;
            err_cnt     <= '0;
            retrain_cnt <= '0;
        end else if (clear_stats) begin
            frame_cnt   <= '0;
            err_cnt     <= '0;
            retrain_cnt <= '0;
        end else begin
            if (cmp_done) begin
                if (frame_cnt == '1) begin
                    frame_cnt <= '0;
                    err_cnt   <= '0;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                    if (!cmp_good) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
            end
            if (retrain_go && retrain_cnt != '1) begin
                retrain_cnt <= retrain_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rx_link_controller.sv
// Directed bench for rx_link_controller with a frame-result scoreboard.
// A second instance starts with frame_cnt at all-ones to reach the wrap path.
module tb_rx_link_controller;
    import rx_link_pkg::*;

    localparam logic [47:0] GOOD_FRAME = 48'hAABBCCDDEEFF;
    localparam logic [47:0] BAD_FRAME  = 48'hAABBCCDDEEFE;

    typedef struct {
        logic        good;
        logic [31:0] frames;
        logic [31:0] errs;
    } sb_entry_t;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        pll_locked;
    logic        clear_stats;

    logic        dru_aresetn, link_up, frame_ok, frame_err;
    logic [2:0]  state;
    logic [31:0] frame_cnt, err_cnt;
    logic [15:0] retrain_cnt;

    logic        dru_aresetn_w, link_up_w, frame_ok_w, frame_err_w;
    logic [2:0]  state_w;
    logic [31:0] frame_cnt_w, err_cnt_w;
    logic [15:0] retrain_cnt_w;

    sb_entry_t   sb[$];
    logic [31:0] mdl_frames;
    logic [31:0] mdl_errs;
    int          checks = 0;
    int          errors = 0;

    rx_link_if rx ();

    always #5 aclk = ~aclk;

    rx_link_controller #(
        .FRAME_LEN(6), .EXPECTED(GOOD_FRAME), .RST_CYCLES(4), .SETTLE_CYCLES(16),
        .LOCK_FRAMES(2), .MAX_ERRS(2), .IDLE_TIMEOUT(100), .FRAME_CNT_INIT(32'h0)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .pll_locked(pll_locked), .rx(rx),
        .clear_stats(clear_stats), .dru_aresetn(dru_aresetn), .link_up(link_up),
        .frame_ok(frame_ok), .frame_err(frame_err), .state(state),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .retrain_cnt(retrain_cnt)
    );

    rx_link_controller #(
        .FRAME_LEN(6), .EXPECTED(GOOD_FRAME), .RST_CYCLES(4), .SETTLE_CYCLES(16),
        .LOCK_FRAMES(2), .MAX_ERRS(2), .IDLE_TIMEOUT(100), .FRAME_CNT_INIT(32'hFFFFFFFF)
    ) dut_w (
        .aclk(aclk), .aresetn(aresetn), .pll_locked(pll_locked), .rx(rx),
        .clear_stats(clear_stats), .dru_aresetn(dru_aresetn_w), .link_up(link_up_w),
        .frame_ok(frame_ok_w), .frame_err(frame_err_w), .state(state_w),
        .frame_cnt(frame_cnt_w), .err_cnt(err_cnt_w), .retrain_cnt(retrain_cnt_w)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bytes go out MSB first; tx_end and clear_stats ride on the last byte only.
    task automatic apply_stimulus(input logic [47:0] data, input int len,
                                  input bit end_frame, input bit clr);
        for (int i = 0; i < len; i++) begin
            rx.byte_valid   = 1'b1;
            rx.decoded_byte = data[47-8*i -: 8];
            rx.tx_end       = end_frame && (i == len - 1);
            clear_stats     = clr && (i == len - 1);
            step();
        end
        rx.byte_valid   = 1'b0;
        rx.decoded_byte = 8'h00;
        rx.tx_end       = 1'b0;
        clear_stats     = 1'b0;
    endtask

    task automatic send_frame(input logic [47:0] data, input int len, input bit good, input bit clr);
        sb_entry_t e;
        if (clr) begin
            mdl_frames = 32'd0;
            mdl_errs   = 32'd0;
        end else begin
            mdl_frames = mdl_frames + 32'd1;
            if (!good) mdl_errs = mdl_errs + 32'd1;
        end
        e.good   = good;
        e.frames = mdl_frames;
        e.errs   = mdl_errs;
        sb.push_back(e);
        apply_stimulus(data, len, 1'b1, clr);
    endtask

    task automatic wait_frame(input string tag);
        sb_entry_t e;
        bit        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            if (frame_ok || frame_err) seen = 1'b1;
            else step();
        end
        e = sb.pop_front();
        check_output({tag, "_pulse"}, 32'(seen), 32'd1);
        check_output({tag, "_ok"}, 32'(frame_ok), 32'(e.good));
        check_output({tag, "_err"}, 32'(frame_err), 32'(!e.good));
        check_output({tag, "_frame_cnt"}, frame_cnt, e.frames);
        check_output({tag, "_err_cnt"}, err_cnt, e.errs);
    endtask

    // Called on the first SETTLE cycle; returns on the first HUNT cycle.
    task automatic settle_check(input string tag);
        int low = 0;
        int n   = 0;
        check_output({tag, "_settle_entry"}, 32'(state), 32'(SETTLE));
        while (state == SETTLE && n < 40) begin
            if (!dru_aresetn) low++;
            step();
            n++;
        end
        check_output({tag, "_settle_len"}, 32'(n), 32'd16);
        check_output({tag, "_dru_low"}, 32'(low), 32'd4);
        check_output({tag, "_hunt"}, 32'(state), 32'(HUNT));
        check_output({tag, "_link_down"}, 32'(link_up), 32'd0);
    endtask

    initial begin
        aresetn         = 1'b0;
        pll_locked      = 1'b0;
        clear_stats     = 1'b0;
        rx.byte_valid   = 1'b0;
        rx.decoded_byte = 8'h00;
        rx.tx_end       = 1'b0;
        mdl_frames      = 32'd0;
        mdl_errs        = 32'd0;
        repeat (3) step();

        check_output("rst_state", 32'(state), 32'(IDLE));
        check_output("rst_dru", 32'(dru_aresetn), 32'd0);
        check_output("rst_link", 32'(link_up), 32'd0);
        check_output("rst_ok", 32'(frame_ok), 32'd0);
        check_output("rst_err", 32'(frame_err), 32'd0);
        check_output("rst_frame_cnt", frame_cnt, 32'd0);
        check_output("rst_err_cnt", err_cnt, 32'd0);
        check_output("rst_retrain_cnt", 32'(retrain_cnt), 32'd0);

        // Power-up with PLL lock arriving ten cycles after reset release
        aresetn = 1'b1;
        repeat (10) step();
        check_output("nolock_idle", 32'(state), 32'(IDLE));
        pll_locked = 1'b1;
        step();
        settle_check("pwr");

        // Two good frames lock the link
        send_frame(GOOD_FRAME, 6, 1'b1, 1'b0);
        wait_frame("lock1");
        check_output("lock1_state", 32'(state), 32'(HUNT));
        check_output("lock1_link", 32'(link_up), 32'd0);
        send_frame(GOOD_FRAME, 6, 1'b1, 1'b0);
        wait_frame("lock2");
        check_output("lock2_state", 32'(state), 32'(LOCKED));
        check_output("lock2_link", 32'(link_up), 32'd1);

        // Mismatching frame then short frame force a retrain
        send_frame(BAD_FRAME, 6, 1'b0, 1'b0);
        wait_frame("bad1");
        check_output("bad1_state", 32'(state), 32'(LOCKED));
        send_frame(48'hAABBCCDDEE00, 5, 1'b0, 1'b0);
        wait_frame("short");
        check_output("short_state", 32'(state), 32'(RETRAIN));
        check_output("short_link", 32'(link_up), 32'd0);
        check_output("short_retrain_cnt", 32'(retrain_cnt), 32'd1);
        step();
        settle_check("retrain");

        // Silence timeout after relocking
        send_frame(GOOD_FRAME, 6, 1'b1, 1'b0);
        wait_frame("relock1");
        send_frame(GOOD_FRAME, 6, 1'b1, 1'b0);
        wait_frame("relock2");
        repeat (99) step();
        check_output("idle99_state", 32'(state), 32'(LOCKED));
        step();
        check_output("idle100_state", 32'(state), 32'(RETRAIN));
        check_output("idle100_retrain_cnt", 32'(retrain_cnt), 32'd2);
        step();
        settle_check("idle");

        // A byte landing on the timeout cycle wins over the timeout
        send_frame(GOOD_FRAME, 6, 1'b1, 1'b0);
        wait_frame("relock3");
        send_frame(GOOD_FRAME, 6, 1'b1, 1'b0);
        wait_frame("relock4");
        repeat (99) step();
        send_frame(GOOD_FRAME, 6, 1'b1, 1'b0);
        wait_frame("byte_wins");
        check_output("byte_wins_state", 32'(state), 32'(LOCKED));
        check_output("byte_wins_retrain_cnt", 32'(retrain_cnt), 32'd2);

        // PLL drop mid-frame flushes the partial frame
        apply_stimulus(GOOD_FRAME, 3, 1'b0, 1'b0);
        pll_locked = 1'b0;
        step();
        check_output("drop_state", 32'(state), 32'(IDLE));
        check_output("drop_link", 32'(link_up), 32'd0);
        check_output("drop_dru", 32'(dru_aresetn), 32'd0);
        pll_locked = 1'b1;
        step();
        settle_check("pllrelock");
        send_frame(GOOD_FRAME, 6, 1'b1, 1'b0);
        wait_frame("clean");
        check_output("clean_state", 32'(state), 32'(HUNT));

        // Asynchronous reset in the middle of a frame
        apply_stimulus(GOOD_FRAME, 3, 1'b0, 1'b0);
        #2 aresetn = 1'b0;
        #1;
        check_output("async_state", 32'(state), 32'(IDLE));
        check_output("async_dru", 32'(dru_aresetn), 32'd0);
        check_output("async_frame_cnt", frame_cnt, 32'd0);
        check_output("async_frame_cnt_w", frame_cnt_w, 32'hFFFFFFFF);
        mdl_frames = 32'd0;
        mdl_errs   = 32'd0;
        step();
        aresetn = 1'b1;
        step();
        settle_check("postrst");
        check_output("w_state", 32'(state_w), 32'(HUNT));
        check_output("w_dru", 32'(dru_aresetn_w), 32'd1);
        check_output("w_link", 32'(link_up_w), 32'd0);
        check_output("w_retrain_cnt", 32'(retrain_cnt_w), 32'd0);

        // Bad frame wraps the preloaded instance; then clear beats an increment
        send_frame(BAD_FRAME, 6, 1'b0, 1'b0);
        wait_frame("wrap");
        check_output("wrap_err_w", 32'(frame_err_w), 32'd1);
        check_output("wrap_ok_w", 32'(frame_ok_w), 32'd0);
        check_output("wrap_frame_cnt_w", frame_cnt_w, 32'd0);
        check_output("wrap_err_cnt_w", err_cnt_w, 32'd0);
        send_frame(GOOD_FRAME, 6, 1'b1, 1'b1);
        wait_frame("clear");
        check_output("clear_frame_cnt_w", frame_cnt_w, 32'd0);
        check_output("clear_err_cnt_w", err_cnt_w, 32'd0);
        check_output("clear_state", 32'(state), 32'(HUNT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
